// File: rtl/mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_burst_ctrl
//
// Turns a single burst command (direction, start address, beat count) into a
// sequence of single-beat memory requests. Write bursts pull one beat at a
// time from the write-data stream and issue it to memory. Read bursts issue
// one read at a time and push the returned word onto the read-data stream.
// Addresses wrap modulo DEPTH. A zero-length or over-long command finishes
// at once with an error pulse and no memory access.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; ready only when idle
//   cmd_wr_i              1 = write burst, 0 = read burst
//   cmd_addr_i            start address
//   cmd_len_i             beat count (legal range 1..DEPTH)
//   s_valid_i/s_data_i/s_ready_o   write-data stream in
//   m_valid_o/m_data_o/m_ready_i   read-data stream out
//   valid_o, wr_en_o, rd_en_o, addr_o, wdata_o   memory request
//   ready_i, rdata_i      memory completion and read data
//   busy_o                high whenever a burst is in progress
//   done_o                one-cycle pulse at the end of every command
//   err_o                 pulses with done_o for an illegal length
// ---------------------------------------------------------------------------
module mem_burst_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int ADDRWIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_wr_i,
    input  logic [ADDRWIDTH-1:0] cmd_addr_i,
    input  logic [ADDRWIDTH:0]   cmd_len_i,
    input  logic                 s_valid_i,
    input  logic [WIDTH-1:0]     s_data_i,
    output logic                 s_ready_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic                 valid_o,
    output logic                 wr_en_o,
    output logic                 rd_en_o,
    output logic [ADDRWIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]     wdata_o,
    input  logic                 ready_i,
    input  logic [WIDTH-1:0]     rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_REQ,
        RD_REQ,
        RD_OUT,
        DONE
    } state_t;

    localparam logic [ADDRWIDTH:0]   LEN_MAX   = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH:0]   LEN_ONE   = (ADDRWIDTH + 1)'(1);
    localparam logic [ADDRWIDTH-1:0] ADDR_LAST = ADDRWIDTH'(DEPTH - 1);
    localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = ADDRWIDTH'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [ADDRWIDTH:0]     cnt_q;
    logic                   wr_q;
    logic                   err_q;
    logic [WIDTH-1:0]       wdata_q;
    logic [WIDTH-1:0]       mdata_q;

    logic                   len_bad;
    logic                   last_beat;
    logic [ADDRWIDTH-1:0]   addr_next;
    state_t                 beat_state;

    assign len_bad   = (cmd_len_i == '0) || (cmd_len_i > LEN_MAX);
    assign last_beat = (cnt_q == LEN_ONE);
    // Explicit wrap so a non-power-of-two DEPTH still wraps at DEPTH-1.
    assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
    // Where the FSM goes after a beat that is not the last one.
    assign beat_state = wr_q ? WR_DATA : RD_REQ;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        valid_o     = 1'b0;
        wr_en_o     = 1'b0;
        rd_en_o     = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        err_o       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (len_bad) begin
                        state_d = DONE;
                    end else begin
                        state_d = cmd_wr_i ? WR_DATA : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                valid_o = 1'b1;
                wr_en_o = 1'b1;
                if (ready_i) begin
                    state_d = last_beat ? DONE : beat_state;
                end
            end
            RD_REQ: begin
                valid_o = 1'b1;
                rd_en_o = 1'b1;
                if (ready_i) begin
                    state_d = RD_OUT;
                end
            end
            RD_OUT: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    state_d = last_beat ? DONE : beat_state;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset as well as the FSM, because the
    // request and stream outputs they drive must read zero during reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            mdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q <= cmd_addr_i;
                        cnt_q  <= cmd_len_i;
                        wr_q   <= cmd_wr_i;
                        err_q  <= len_bad;
                    end
                end
                WR_DATA: begin
                    if (s_valid_i) begin
                        wdata_q <= s_data_i;
                    end
                end
                WR_REQ: begin
                    if (ready_i) begin
                        addr_q <= addr_next;
                        cnt_q  <= cnt_q - LEN_ONE;
                    end
                end
                RD_REQ: begin
                    if (ready_i) begin
                        mdata_q <= rdata_i;
                    end
                end
                RD_OUT: begin
                    if (m_ready_i) begin
                        addr_q <= addr_next;
                        cnt_q  <= cnt_q - LEN_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign m_data_o = mdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_ctrl
//
// Drives bursts through mem_burst_ctrl against a behavioural memory and
// stream environment. The reference model is an array holding the memory
// contents plus the rule that beat i of a burst touches (addr + i) mod DEPTH.
// A table of directed bursts runs first, then a reset-mid-burst sequence,
// then randomized bursts with noise on every ignored input.
// ---------------------------------------------------------------------------
module tb_mem_burst_ctrl;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 16;
    localparam int ADDRWIDTH = 4;
    localparam int BUDGET    = 2000;

    logic                 clk_i;
    logic                 rst_i;
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic                 cmd_wr_i;
    logic [ADDRWIDTH-1:0] cmd_addr_i;
    logic [ADDRWIDTH:0]   cmd_len_i;
    logic                 s_valid_i;
    logic [WIDTH-1:0]     s_data_i;
    logic                 s_ready_o;
    logic                 m_valid_o;
    logic [WIDTH-1:0]     m_data_o;
    logic                 m_ready_i;
    logic                 valid_o;
    logic                 wr_en_o;
    logic                 rd_en_o;
    logic [ADDRWIDTH-1:0] addr_o;
    logic [WIDTH-1:0]     wdata_o;
    logic                 ready_i;
    logic [WIDTH-1:0]     rdata_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    mem_burst_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_wr_i   (cmd_wr_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_len_i  (cmd_len_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .m_valid_o  (m_valid_o),
        .m_data_o   (m_data_o),
        .m_ready_i  (m_ready_i),
        .valid_o    (valid_o),
        .wr_en_o    (wr_en_o),
        .rd_en_o    (rd_en_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .ready_i    (ready_i),
        .rdata_i    (rdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic wr;
        int   addr;
        int   len;
        int   delay;      // cycles memory waits before raising ready_i
        int   stall;      // read beat on which m_ready_i is held low 3 cycles
        bit   noise;      // randomize the inputs the DUT must ignore
        int   exp_reqs;   // memory requests expected
        int   exp_outs;   // read-stream beats expected
        int   exp_err;    // err_o pulses expected
    } vec_t;

    int               errors;
    int               checks;
    logic [WIDTH-1:0] ref_mem  [DEPTH];
    logic [WIDTH-1:0] wdata_arr[32];
    vec_t             vecs[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid_o"},     valid_o,     0);
        check({tag, " wr_en_o"},     wr_en_o,     0);
        check({tag, " rd_en_o"},     rd_en_o,     0);
        check({tag, " addr_o"},      addr_o,      0);
        check({tag, " wdata_o"},     wdata_o,     0);
        check({tag, " m_valid_o"},   m_valid_o,   0);
        check({tag, " m_data_o"},    m_data_o,    0);
        check({tag, " s_ready_o"},   s_ready_o,   0);
        check({tag, " busy_o"},      busy_o,      0);
        check({tag, " done_o"},      done_o,      0);
        check({tag, " err_o"},       err_o,       0);
        check({tag, " cmd_ready_o"}, cmd_ready_o, 1);
    endtask

    // Runs one command to completion (or until the planted reset when
    // abort_beat >= 0), acting as stream source/sink and memory.
    task automatic run_burst(input vec_t v, input int abort_beat);
        int req_count = 0;
        int out_count = 0;
        int s_idx     = 0;
        int wait_cnt  = 0;
        int hold_cnt  = 0;
        int dones     = 0;
        int errs      = 0;
        bit in_req    = 0;
        bit in_out    = 0;
        bit finished  = 0;
        bit aborted   = 0;
        bit prev_hs   = 0;
        logic [ADDRWIDTH-1:0] req_addr = '0;
        logic [WIDTH-1:0]     req_wd   = '0;
        logic [WIDTH-1:0]     held     = '0;
        logic                 req_wr   = 1'b0;

        for (int i = 0; i < 32; i++) wdata_arr[i] = WIDTH'($urandom);

        @(negedge clk_i);
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = v.wr;
        cmd_addr_i  = ADDRWIDTH'(v.addr);
        cmd_len_i   = (ADDRWIDTH + 1)'(v.len);
        s_valid_i   = 1'b0;
        ready_i     = 1'b0;
        m_ready_i   = 1'b0;

        for (int cyc = 0; cyc < BUDGET && !finished && !aborted; cyc++) begin
            @(negedge clk_i);
            if (v.noise) begin
                cmd_valid_i = 1'($urandom);
                cmd_wr_i    = 1'($urandom);
                cmd_addr_i  = ADDRWIDTH'($urandom);
                cmd_len_i   = (ADDRWIDTH + 1)'($urandom);
            end else begin
                cmd_valid_i = 1'b0;
            end

            if (abort_beat >= 0 && req_count == abort_beat && s_ready_o) begin
                cmd_valid_i = 1'b0;
                rst_i       = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                aborted = 1;
            end else begin
                check("busy_o", busy_o, 1);
                check("err_only_with_done", err_o & ~done_o, 0);
                if (done_o) begin
                    dones++;
                    if (err_o) errs++;
                    finished = 1;
                end
                if (prev_hs) check("req_gap", valid_o, 0);
                prev_hs = 0;

                // Memory side.
                if (valid_o) begin
                    if (!in_req) begin
                        in_req   = 1;
                        wait_cnt = 0;
                        req_addr = addr_o;
                        req_wd   = wdata_o;
                        req_wr   = wr_en_o;
                        check("addr_o", addr_o, (v.addr + req_count) % DEPTH);
                        check("wr_en_o", wr_en_o, v.wr);
                        check("rd_en_o", rd_en_o, !v.wr);
                        if (v.wr) check("wdata_o", wdata_o, wdata_arr[req_count]);
                    end else begin
                        check("addr_stable", addr_o, req_addr);
                        check("wdata_stable", wdata_o, req_wd);
                        check("wr_en_stable", wr_en_o, req_wr);
                    end
                    if (wait_cnt >= v.delay) begin
                        ready_i = 1'b1;
                        rdata_i = ref_mem[addr_o];
                        if (wr_en_o) ref_mem[addr_o] = wdata_o;
                        in_req  = 0;
                        prev_hs = 1;
                        req_count++;
                    end else begin
                        ready_i = 1'b0;
                        rdata_i = WIDTH'($urandom);
                        wait_cnt++;
                    end
                end else begin
                    if (in_req) check("valid_held", valid_o, 1);
                    in_req  = 0;
                    ready_i = v.noise ? 1'($urandom) : 1'b0;
                    rdata_i = WIDTH'($urandom);
                end

                // Write-data source.
                s_valid_i = v.noise ? 1'($urandom) : 1'b1;
                if (s_valid_i && s_ready_o && s_idx < 32) begin
                    s_data_i = wdata_arr[s_idx];
                    s_idx++;
                end else begin
                    s_data_i = WIDTH'($urandom);
                end

                // Read-data sink.
                if (m_valid_o) begin
                    if (!in_out) begin
                        in_out   = 1;
                        hold_cnt = 0;
                        held     = m_data_o;
                        check("m_data_o", m_data_o, ref_mem[(v.addr + out_count) % DEPTH]);
                    end else begin
                        check("m_data_stable", m_data_o, held);
                    end
                    if (out_count == v.stall && hold_cnt < 3) begin
                        m_ready_i = 1'b0;
                        hold_cnt++;
                        check("stall_no_req", valid_o, 0);
                    end else begin
                        m_ready_i = v.noise ? 1'($urandom) : 1'b1;
                    end
                    if (m_ready_i) begin
                        out_count++;
                        in_out = 0;
                    end
                end else begin
                    if (in_out) check("m_valid_held", m_valid_o, 1);
                    in_out    = 0;
                    m_ready_i = v.noise ? 1'($urandom) : 1'b0;
                end
            end
        end

        if (!aborted) begin
            check("burst_finished", finished, 1);
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            s_valid_i   = 1'b0;
            ready_i     = 1'b0;
            m_ready_i   = 1'b0;
            check("done_one_cycle", done_o, 0);
            check("back_to_idle", cmd_ready_o, 1);
            check("idle_not_busy", busy_o, 0);
            check("req_count", req_count, v.exp_reqs);
            check("out_count", out_count, v.exp_outs);
            check("done_pulses", dones, 1);
            check("err_pulses", errs, v.exp_err);
        end
    endtask

    initial begin
        vec_t v;
        errors      = 0;
        checks      = 0;
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        s_valid_i   = 1'b0;
        s_data_i    = '0;
        m_ready_i   = 1'b0;
        ready_i     = 1'b0;
        rdata_i     = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Directed table: wr, addr, len, delay, stall, noise, reqs, outs, err.
        vecs.push_back('{1'b1,  0, 16, 1, -1, 1'b0, 16,  0, 0}); // full write
        vecs.push_back('{1'b0,  0, 16, 1,  4, 1'b0, 16, 16, 0}); // read back, stall beat 5
        vecs.push_back('{1'b1, 14,  4, 1, -1, 1'b0,  4,  0, 0}); // write wrap 14,15,0,1
        vecs.push_back('{1'b1,  3,  0, 1, -1, 1'b0,  0,  0, 1}); // len 0
        vecs.push_back('{1'b0,  3, 17, 1, -1, 1'b0,  0,  0, 1}); // len 17
        vecs.push_back('{1'b1,  2,  5, 4, -1, 1'b0,  5,  0, 0}); // ready_i backpressure
        vecs.push_back('{1'b0, 14,  4, 0,  0, 1'b0,  4,  4, 0}); // read wrap, stall beat 1
        vecs.push_back('{1'b0,  9,  1, 0, -1, 1'b0,  1,  1, 0}); // single beat read

        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b1;

        foreach (vecs[i]) run_burst(vecs[i], -1);

        // Reset during beat 3 of a len 8 write, then a clean len 2 write at 5.
        v = '{1'b1, 0, 8, 1, -1, 1'b0, 0, 0, 0};
        run_burst(v, 2);
        repeat (2) @(negedge clk_i);
        check_reset_outputs("held_reset");
        rst_i = 1'b1;
        @(negedge clk_i);
        check("no_done_after_reset", done_o, 0);
        v = '{1'b1, 5, 2, 1, -1, 1'b0, 2, 0, 0};
        run_burst(v, -1);

        // Randomized bursts checked against the memory model.
        for (int n = 0; n < 24; n++) begin
            bit legal;
            v.wr    = 1'($urandom);
            v.addr  = $urandom_range(0, DEPTH - 1);
            v.len   = $urandom_range(0, DEPTH + 2);
            v.delay = $urandom_range(0, 3);
            v.stall = $urandom_range(0, (v.len > 0) ? v.len - 1 : 0);
            v.noise = 1'b1;
            legal      = (v.len >= 1) && (v.len <= DEPTH);
            v.exp_reqs = legal ? v.len : 0;
            v.exp_outs = (legal && !v.wr) ? v.len : 0;
            v.exp_err  = legal ? 0 : 1;
            run_burst(v, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16, data width.
- DEPTH, default 16, memory locations.
- ADDRWIDTH, default $clog2(DEPTH), address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_wr_i  in  1  1 = burst write, 0 = burst read.
- cmd_addr_i  in  ADDRWIDTH  start address.
- cmd_len_i  in  ADDRWIDTH+1  beat count.
- s_valid_i, s_data_i, s_ready_o  in/in/out  1/WIDTH/1  write-data stream.
- m_valid_o, m_data_o, m_ready_i  out/out/in  1/WIDTH/1  read-data stream.
- valid_o, wr_en_o, rd_en_o, addr_o, wdata_o  out  1/1/1/ADDRWIDTH/WIDTH  memory request.
- ready_i, rdata_i  in  1/WIDTH  memory completion and read data.
- busy_o, done_o, err_o  out  1  status.

Function
REQ-003 FSM states SHALL be IDLE, WR_DATA, WR_REQ, RD_REQ, RD_OUT, DONE.
REQ-004 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_valid_i and cmd_ready_o are both high.
REQ-005 When a command is accepted, the block SHALL latch address, length and direction.
REQ-006 A command with 1 <= len <= DEPTH SHALL go to WR_DATA (write) or RD_REQ (read).
REQ-007 A command with len == 0 or len > DEPTH SHALL go to DONE with no memory access, and err_o SHALL pulse for 1 cycle together with done_o.
REQ-008 In WR_DATA, s_ready_o SHALL be 1. A beat is taken when s_valid_i is high: s_data_i is captured into wdata_o and the FSM goes to WR_REQ.
REQ-009 In WR_REQ, valid_o and wr_en_o SHALL be 1 and rd_en_o 0; addr_o, wdata_o and the enables SHALL stay stable until ready_i is sampled high.
REQ-010 In RD_REQ, valid_o and rd_en_o SHALL be 1 and wr_en_o 0. rdata_i SHALL be captured into m_data_o on the cycle ready_i is high, then the FSM goes to RD_OUT.
REQ-011 In RD_OUT, m_valid_o SHALL be 1 and m_data_o SHALL stay stable until m_ready_i is high.
REQ-012 Each beat completes on ready_i (write) or on the m_valid_o/m_ready_i handshake (read). On completion, the address SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) and the remaining count SHALL decrement.
REQ-013 When the remaining count is nonzero after a beat, the FSM SHALL return to WR_DATA or RD_REQ; when it reaches zero, the FSM SHALL go to DONE.
REQ-014 DONE SHALL last 1 cycle, assert done_o for that cycle, then return to IDLE.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 valid_o SHALL be 0 in IDLE, WR_DATA, RD_OUT and DONE.
REQ-017 Throughput SHALL be at most one memory request per 2 cycles. Minimum per-beat latency SHALL be 2 cycles for writes and 2 cycles for reads.
REQ-018 ready_i going high while valid_o is 0 SHALL be ignored.
REQ-019 s_valid_i and m_ready_i SHALL be ignored outside WR_DATA and RD_OUT respectively.
REQ-020 cmd_valid_i SHALL be ignored while busy_o is 1; there is no command queueing.

Reset
REQ-021 When rst_i is low, the FSM SHALL go to IDLE immediately, and all of these SHALL be 0 without waiting for a clock edge: valid_o, wr_en_o, rd_en_o, addr_o, wdata_o, m_valid_o, m_data_o, s_ready_o, busy_o, done_o, err_o, and the internal address and count registers.
REQ-022 In IDLE after reset, cmd_ready_o SHALL be 1.
REQ-023 Reset during a burst SHALL abandon the burst with no done_o pulse; the next command SHALL start cleanly.

Verification
REQ-024 Write burst, addr 0, len 16, memory ready_i 1 cycle after valid_o:
- 16 writes with addr_o 0..15 in order.
- wdata_o equals each s_data_i beat.
- done_o pulses once, err_o stays 0.
REQ-025 Read burst, addr 0, len 16, after REQ-024:
- m_data_o sequence equals the written data.
- m_ready_i held low for 3 cycles on beat 5; m_data_o stays stable and no new request is issued.
REQ-026 Wrap: write addr 14, len 4 -> addr_o sequence 14, 15, 0, 1, then done_o.
REQ-027 Illegal length:
- len 0 -> done_o and err_o pulse together, valid_o never 1.
- len 17 -> same response.
REQ-028 Reset mid-burst: rst_i low during beat 3 of a len 8 write:
- All outputs 0 immediately.
- A following write of len 2 at addr 5 completes with addr_o 5, 6.
REQ-029 ready_i backpressure: ready_i delayed 4 cycles on every beat -> valid_o, addr_o and wdata_o stay stable, with exactly one request per beat.
